// File: rtl/srl_fifo_fwft_ctrl.sv
// srl_fifo_fwft_ctrl
// Shift-register FIFO with a registered first-word-fall-through output stage.
// Words enter at SRL entry 0 and move one place deeper on every push, so the
// oldest word in the SRL always sits at entry count-1. A separate output
// register presents the head word to the consumer. Total capacity is DEPTH+1.
// Occupancy, full and almost-full flags are all registered. Each flag's
// next-state value is computed from the next-state count and output-valid
// bit, so no flag depends combinationally on the current cycle's handshakes.
module srl_fifo_fwft_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 4,
  parameter int AF_MARGIN  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  output logic                  if_almost_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CAP_C   = CW'(DEPTH + 1);
  localparam logic [CW-1:0] AFM_C   = CW'(AF_MARGIN);

  // SRL storage holds data only and is deliberately left without reset.
  logic [DATA_WIDTH-1:0] srl_q [DEPTH];

  logic [CW-1:0]         count_q, count_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  full_n_q, full_n_d;
  logic                  afull_n_q, afull_n_d;
  logic [CW-1:0]         num_q, num_d;

  logic                  push;
  logic                  pop;
  logic                  load;
  logic                  srl_we;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // Handshakes, output-stage load and next-state occupancy and flags.
  always_comb begin
    push    = if_write & if_write_ce & full_n_q;
    pop     = if_read & if_read_ce & valid_q;
    // Only words already resident in the SRL may be loaded. A word pushed
    // this cycle is not visible yet, so there is no write-to-read bypass.
    load    = (~valid_q | pop) & (count_q != '0);
    // Read address uses the pre-shift count. This selects the oldest word
    // even when a push shifts the SRL on the same edge.
    rd_addr = ADDR_WIDTH'(count_q - CW'(1));
    srl_we  = push & ~flush;

    count_d = count_q;
    valid_d = valid_q;
    dout_d  = dout_q;

    if (push && !load) begin
      count_d = count_q + CW'(1);
    end else if (!push && load) begin
      count_d = count_q - CW'(1);
    end

    if (load) begin
      valid_d = 1'b1;
      dout_d  = srl_q[rd_addr];
    end else if (pop) begin
      valid_d = 1'b0;
    end

    // Flush discards the cycle's push and pop. The output data word is left
    // as-is because it is meaningless once valid drops.
    if (flush) begin
      count_d = '0;
      valid_d = 1'b0;
      dout_d  = dout_q;
    end

    num_d     = count_d + CW'(valid_d);
    full_n_d  = (count_d != DEPTH_C);
    afull_n_d = ((CAP_C - num_d) > AFM_C);
  end

  // Control state and output register: async clear on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      valid_q   <= 1'b0;
      dout_q    <= '0;
      full_n_q  <= 1'b1;
      afull_n_q <= (CAP_C > AFM_C);
      num_q     <= '0;
    end else begin
      count_q   <= count_d;
      valid_q   <= valid_d;
      dout_q    <= dout_d;
      full_n_q  <= full_n_d;
      afull_n_q <= afull_n_d;
      num_q     <= num_d;
    end
  end

  // Shift register store: every accepted push moves entries one place deeper.
  always_ff @(posedge clk) begin
    if (srl_we) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        srl_q[i] <= srl_q[i-1];
      end
      srl_q[0] <= if_din;
    end
  end

  assign if_full_n         = full_n_q;
  assign if_almost_full_n  = afull_n_q;
  assign if_dout           = dout_q;
  assign if_empty_n        = valid_q;
  assign if_num_data_valid = num_q;

endmodule
